// File: rtl/decode_extract_imm.sv
// A64-subset instruction classifier and immediate extractor for the fetch/decode front end.
// Same-cycle opcode/immediate for fetch plus a one-stage registered copy for dispatch.

package decode_extract_imm_pkg;

    typedef enum logic [4:0] {
        OP_ERROR,
        OP_NOP,
        OP_HLT,
        OP_B,
        OP_BL,
        OP_B_COND,
        OP_CBZ,
        OP_CBNZ,
        OP_RET,
        OP_BR,
        OP_BLR,
        OP_LDUR,
        OP_STUR,
        OP_MOVZ,
        OP_MOVK,
        OP_ADR,
        OP_ADRP,
        OP_ADD,
        OP_ADDS,
        OP_SUB,
        OP_SUBS,
        OP_AND,
        OP_ANDS,
        OP_ORR,
        OP_EOR,
        OP_MVN
    } opcode_t;

    // Which instruction field feeds the extended immediate.
    typedef enum logic [2:0] {
        IMM_ZERO,
        IMM_BR26,
        IMM_BR19,
        IMM_MEM9,
        IMM_MOV16,
        IMM_ADR,
        IMM_ADRP,
        IMM_ARITH12
    } imm_sel_t;

endpackage

module decode_extract_imm
    import decode_extract_imm_pkg::*;
#(
    parameter int GPR_SIZE = 64
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic [31:0]         in_insnbits,
    input  logic                in_valid,
    output opcode_t             out_opcode,
    output logic [GPR_SIZE-1:0] out_reg_imm,
    output opcode_t             out_q_opcode,
    output logic [GPR_SIZE-1:0] out_q_imm,
    output logic                out_q_valid
);

    typedef logic [GPR_SIZE-1:0] gpr_t;

    logic [31:0] insn;
    opcode_t     opcode;
    imm_sel_t    imm_sel;
    gpr_t        reg_imm;

    logic        no_shift;
    logic        rn_is_zr;

    gpr_t        imm_br26;
    gpr_t        imm_br19;
    gpr_t        imm_mem9;
    gpr_t        imm_mov16;
    gpr_t        imm_adr;
    gpr_t        imm_adrp;
    gpr_t        imm_arith12;

    opcode_t     opcode_d, opcode_q;
    gpr_t        imm_d, imm_q;
    logic        valid_d, valid_q;

    assign insn     = in_insnbits;
    assign no_shift = (insn[15:10] == 6'd0);
    assign rn_is_zr = (insn[9:5] == 5'b11111);

    // All shifts happen on the already-extended value, so bits pushed past GPR_SIZE-1 drop out.
    assign imm_br26    = gpr_t'({{(GPR_SIZE-26){insn[25]}}, insn[25:0]}) << 2;
    assign imm_br19    = gpr_t'({{(GPR_SIZE-19){insn[23]}}, insn[23:5]}) << 2;
    assign imm_mem9    = {{(GPR_SIZE-9){insn[20]}}, insn[20:12]};
    assign imm_mov16   = gpr_t'(insn[20:5]) << {insn[22:21], 4'b0000};
    assign imm_adr     = {{(GPR_SIZE-21){insn[23]}}, insn[23:5], insn[30:29]};
    assign imm_adrp    = imm_adr << 12;
    assign imm_arith12 = gpr_t'(insn[21:10]);

    // The encodings are mutually exclusive, so the order of this chain carries no priority.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        opcode  = OP_ERROR;
        imm_sel = IMM_ZERO;

        if (insn[31:26] == 6'b000101) begin
            opcode  = OP_B;
            imm_sel = IMM_BR26;
        end else if (insn[31:26] == 6'b100101) begin
            opcode  = OP_BL;
            imm_sel = IMM_BR26;
        end else if (insn[31:24] == 8'b01010100 && !insn[4]) begin
            opcode  = OP_B_COND;
            imm_sel = IMM_BR19;
        end else if (insn[31:24] == 8'b10110100) begin
            opcode  = OP_CBZ;
            imm_sel = IMM_BR19;
        end else if (insn[31:24] == 8'b10110101) begin
            opcode  = OP_CBNZ;
            imm_sel = IMM_BR19;
        end else if (insn[31:10] == 22'b1101011001011111000000 && insn[4:0] == 5'd0) begin
            opcode = OP_RET;
        end else if (insn[31:10] == 22'b1101011000011111000000 && insn[4:0] == 5'd0) begin
            opcode = OP_BR;
        end else if (insn[31:10] == 22'b1101011000111111000000 && insn[4:0] == 5'd0) begin
            opcode = OP_BLR;
        end else if (insn == 32'hD503201F) begin
            opcode = OP_NOP;
        end else if (insn[31:21] == 11'b11010100010 && insn[4:0] == 5'd0) begin
            opcode = OP_HLT;
        end else if (insn[31:21] == 11'b11111000010 && insn[11:10] == 2'b00) begin
            opcode  = OP_LDUR;
            imm_sel = IMM_MEM9;
        end else if (insn[31:21] == 11'b11111000000 && insn[11:10] == 2'b00) begin
            opcode  = OP_STUR;
            imm_sel = IMM_MEM9;
        end else if (insn[31:23] == 9'b110100101) begin
            opcode  = OP_MOVZ;
            imm_sel = IMM_MOV16;
        end else if (insn[31:23] == 9'b111100101) begin
            opcode  = OP_MOVK;
            imm_sel = IMM_MOV16;
        end else if (!insn[31] && insn[28:24] == 5'b10000) begin
            opcode  = OP_ADR;
            imm_sel = IMM_ADR;
        end else if (insn[31] && insn[28:24] == 5'b10000) begin
            opcode  = OP_ADRP;
            imm_sel = IMM_ADRP;
        end else if (insn[31:22] == 10'b1001000100) begin
            opcode  = OP_ADD;
            imm_sel = IMM_ARITH12;
        end else if (insn[31:22] == 10'b1011000100) begin
            opcode  = OP_ADDS;
            imm_sel = IMM_ARITH12;
        end else if (insn[31:22] == 10'b1101000100) begin
            opcode  = OP_SUB;
            imm_sel = IMM_ARITH12;
        end else if (insn[31:22] == 10'b1111000100) begin
            opcode  = OP_SUBS;
            imm_sel = IMM_ARITH12;
        end else if (no_shift) begin
            // Shifted-register forms are only recognised with a zero shift amount.
            unique case (insn[31:21])
                11'b10001011000: opcode = OP_ADD;
                11'b10101011000: opcode = OP_ADDS;
                11'b11001011000: opcode = OP_SUB;
                11'b11101011000: opcode = OP_SUBS;
                11'b10001010000: opcode = OP_AND;
                11'b11101010000: opcode = OP_ANDS;
                11'b10101010000: opcode = OP_ORR;
                11'b11001010000: opcode = OP_EOR;
                11'b10101010001: opcode = rn_is_zr ? OP_MVN : OP_ERROR;
                default:         opcode = OP_ERROR;
            endcase
        end
    end

    always_comb begin
        reg_imm = '0;
        unique case (imm_sel)
            IMM_BR26:    reg_imm = imm_br26;
            IMM_BR19:    reg_imm = imm_br19;
            IMM_MEM9:    reg_imm = imm_mem9;
            IMM_MOV16:   reg_imm = imm_mov16;
            IMM_ADR:     reg_imm = imm_adr;
            IMM_ADRP:    reg_imm = imm_adrp;
            IMM_ARITH12: reg_imm = imm_arith12;
            default:     reg_imm = '0;
        endcase
    end

    assign out_opcode  = opcode;
    assign out_reg_imm = reg_imm;

    // Opcode and immediate are captured even when invalid; the valid bit qualifies them downstream.
    always_comb begin
        opcode_d = opcode;
        imm_d    = reg_imm;
        valid_d  = in_valid;
    end

    always_ff @(posedge in_clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (in_rst) begin
            opcode_q <= OP_NOP;
            imm_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            valid_q  <= valid_d;
        end
    end

    assign out_q_opcode = opcode_q;
    assign out_q_imm    = imm_q;
    assign out_q_valid  = valid_q;

endmodule

// File: tb/tb_decode_extract_imm.sv
// Directed self-checking bench for decode_extract_imm: vector table for decode, hand sequences for reset.

module tb_decode_extract_imm;
    import decode_extract_imm_pkg::*;

    localparam int GPR_SIZE = 64;

    logic                in_clk;
    logic                in_rst;
    logic [31:0]         in_insnbits;
    logic                in_valid;
    opcode_t             out_opcode;
    logic [GPR_SIZE-1:0] out_reg_imm;
    opcode_t             out_q_opcode;
    logic [GPR_SIZE-1:0] out_q_imm;
    logic                out_q_valid;

    int n_checks = 0;
    int n_fail   = 0;

    decode_extract_imm #(.GPR_SIZE(GPR_SIZE)) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_insnbits  (in_insnbits),
        .in_valid     (in_valid),
        .out_opcode   (out_opcode),
        .out_reg_imm  (out_reg_imm),
        .out_q_opcode (out_q_opcode),
        .out_q_imm    (out_q_imm),
        .out_q_valid  (out_q_valid)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [31:0] insn;
        opcode_t     op;
        logic [63:0] imm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_op(input string name, input opcode_t act, input opcode_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act.name(), exp.name());
        end
    endtask

    initial begin
        in_rst      = 1'b1;
        in_valid    = 1'b1;
        in_insnbits = 32'h14000001;

        vecs.push_back('{32'h14000001, OP_B,      64'h4});
        vecs.push_back('{32'h17FFFFFF, OP_B,      64'hFFFFFFFFFFFFFFFC});
        vecs.push_back('{32'h94000010, OP_BL,     64'h40});
        vecs.push_back('{32'h54000040, OP_B_COND, 64'h8});
        vecs.push_back('{32'h54FFFFE0, OP_B_COND, 64'hFFFFFFFFFFFFFFFC});
        vecs.push_back('{32'h54000050, OP_ERROR,  64'h0});
        vecs.push_back('{32'hB4FFFFE0, OP_CBZ,    64'hFFFFFFFFFFFFFFFC});
        vecs.push_back('{32'hB5000040, OP_CBNZ,   64'h8});
        vecs.push_back('{32'hD65F03C0, OP_RET,    64'h0});
        vecs.push_back('{32'hD65F03C1, OP_ERROR,  64'h0});
        vecs.push_back('{32'hD61F0000, OP_BR,     64'h0});
        vecs.push_back('{32'hD63F0020, OP_BLR,    64'h0});
        vecs.push_back('{32'hD503201F, OP_NOP,    64'h0});
        vecs.push_back('{32'hD4400000, OP_HLT,    64'h0});
        vecs.push_back('{32'hF85F8020, OP_LDUR,   64'hFFFFFFFFFFFFFFF8});
        vecs.push_back('{32'hF8400400, OP_ERROR,  64'h0});
        vecs.push_back('{32'hF80FF000, OP_STUR,   64'hFF});
        vecs.push_back('{32'h91001441, OP_ADD,    64'h5});
        vecs.push_back('{32'hF13FFC00, OP_SUBS,   64'hFFF});
        vecs.push_back('{32'hD2A24680, OP_MOVZ,   64'h12340000});
        vecs.push_back('{32'hF2FFFFE0, OP_MOVK,   64'hFFFF000000000000});
        vecs.push_back('{32'h30000020, OP_ADR,    64'h5});
        vecs.push_back('{32'hF0FFFFE0, OP_ADRP,   64'hFFFFFFFFFFFFF000});
        vecs.push_back('{32'hCB020020, OP_SUB,    64'h0});
        vecs.push_back('{32'hEA020020, OP_ANDS,   64'h0});
        vecs.push_back('{32'hAA0103E0, OP_ORR,    64'h0});
        vecs.push_back('{32'hAA010400, OP_ERROR,  64'h0});
        vecs.push_back('{32'hAA2103E0, OP_MVN,    64'h0});
        vecs.push_back('{32'hAA210020, OP_ERROR,  64'h0});
        vecs.push_back('{32'h00000000, OP_ERROR,  64'h0});
        vecs.push_back('{32'hFFFFFFFF, OP_ERROR,  64'h0});

        // Reset held for two edges while a valid instruction is presented: reset wins.
        @(posedge in_clk);
        @(posedge in_clk);
        #1;
        check("rst q_valid", 64'(out_q_valid), 64'h0);
        check_op("rst q_opcode", out_q_opcode, OP_NOP);
        check("rst q_imm", out_q_imm, 64'h0);
        check_op("comb op during rst", out_opcode, OP_B);
        check("comb imm during rst", out_reg_imm, 64'h4);

        // First capture after reset release.
        @(negedge in_clk);
        in_rst      = 1'b0;
        in_insnbits = 32'h14000001;
        in_valid    = 1'b1;
        @(posedge in_clk);
        #1;
        check("post-rst q_valid", 64'(out_q_valid), 64'h1);
        check_op("post-rst q_opcode", out_q_opcode, OP_B);
        check("post-rst q_imm", out_q_imm, 64'h4);

        // Table: same-cycle decode, then the registered copy after the next edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge in_clk);
            in_insnbits = vecs[i].insn;
            in_valid    = i[0];
            #1;
            check_op($sformatf("comb op %08h", vecs[i].insn), out_opcode, vecs[i].op);
            check($sformatf("comb imm %08h", vecs[i].insn), out_reg_imm, vecs[i].imm);
            @(posedge in_clk);
            #1;
            check_op($sformatf("q op %08h", vecs[i].insn), out_q_opcode, vecs[i].op);
            check($sformatf("q imm %08h", vecs[i].insn), out_q_imm, vecs[i].imm);
            check($sformatf("q valid %08h", vecs[i].insn), 64'(out_q_valid), 64'(i[0]));
        end

        // Reset mid-stream drops the instruction being captured.
        @(negedge in_clk);
        in_insnbits = 32'h94000010;
        in_valid    = 1'b1;
        @(posedge in_clk);
        #1;
        check("stream q_valid", 64'(out_q_valid), 64'h1);
        @(negedge in_clk);
        in_insnbits = 32'h14000001;
        in_valid    = 1'b1;
        in_rst      = 1'b1;
        @(posedge in_clk);
        #1;
        check("mid-rst q_valid", 64'(out_q_valid), 64'h0);
        check_op("mid-rst q_opcode", out_q_opcode, OP_NOP);
        check("mid-rst q_imm", out_q_imm, 64'h0);
        @(negedge in_clk);
        in_rst      = 1'b0;
        in_insnbits = 32'h94000010;
        in_valid    = 1'b1;
        @(posedge in_clk);
        #1;
        check("resume q_valid", 64'(out_q_valid), 64'h1);
        check_op("resume q_opcode", out_q_opcode, OP_BL);
        check("resume q_imm", out_q_imm, 64'h40);

        // Invalid cycle still captures opcode and immediate.
        @(negedge in_clk);
        in_insnbits = 32'hD2A24680;
        in_valid    = 1'b0;
        @(posedge in_clk);
        #1;
        check("invalid q_valid", 64'(out_q_valid), 64'h0);
        check_op("invalid q_opcode", out_q_opcode, OP_MOVZ);
        check("invalid q_imm", out_q_imm, 64'h12340000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_extract_imm.md
# decode_extract_imm

Instruction-classification and immediate-extraction block for the fetch/decode front end of the Tomasulo core. It combinationally maps a 32-bit A64-subset instruction word to an `opcode_t` value and a sign/zero-extended `GPR_SIZE`-bit immediate. Fetch uses these same-cycle outputs for PC prediction. A one-stage registered copy with a valid bit feeds the decode/dispatch stage.

## Interface
- `GPR_SIZE`, default 64: width of the extended immediate.
- `in_clk` input 1: the block's single clock; all state updates on its rising edge.
- `in_rst` input 1: reset, synchronous and active-high.
- `in_insnbits` input 32: instruction word to decode.
- `in_valid` input 1: `in_insnbits` holds a real instruction this cycle.
- `out_opcode` output `opcode_t`: combinational opcode of `in_insnbits`.
- `out_reg_imm` output `GPR_SIZE`: combinational extended immediate of `in_insnbits`.
- `out_q_opcode` output `opcode_t`: registered `out_opcode`.
- `out_q_imm` output `GPR_SIZE`: registered `out_reg_imm`.
- `out_q_valid` output 1: registered `in_valid`.

## Operation
- Decode is priority-free: the encodings below are mutually exclusive. Any word that matches none of them, including 0x00000000, gives `OP_ERROR` with immediate 0.
- Branch and system instructions:
  - `OP_B`: [31:26]=000101. Immediate = sext(imm26[25:0]) << 2.
  - `OP_BL`: [31:26]=100101. Immediate as `OP_B`.
  - `OP_B_COND`: [31:24]=01010100 and [4]=0. Immediate = sext(imm19[23:5]) << 2.
  - `OP_CBZ`: [31:24]=10110100. `OP_CBNZ`: [31:24]=10110101. Immediate as `OP_B_COND`.
  - `OP_RET`, `OP_BR`, `OP_BLR`: [31:10] = 1101011001011111000000, 1101011000011111000000 and 1101011000111111000000 respectively, with [4:0]=0. Immediate 0.
  - `OP_NOP`: word exactly 0xD503201F. `OP_HLT`: [31:21]=11010100010 and [4:0]=0. Immediate 0 for both.
- Memory and move instructions:
  - `OP_LDUR`: [31:21]=11111000010 and [11:10]=00. `OP_STUR`: [31:21]=11111000000 and [11:10]=00. Immediate = sext(imm9[20:12]).
  - `OP_MOVZ`: [31:23]=110100101. `OP_MOVK`: [31:23]=111100101. Immediate = zext(imm16[20:5]) << (16 × hw[22:21]).
  - `OP_ADR`: [31]=0, [28:24]=10000. Immediate = sext({immhi[23:5], immlo[30:29]}).
  - `OP_ADRP`: [31]=1, [28:24]=10000. Immediate = sext({immhi, immlo}) << 12.
- Immediate arithmetic: `OP_ADD`, `OP_ADDS`, `OP_SUB`, `OP_SUBS` are matched on [31:22] = 1001000100, 1011000100, 1101000100 and 1111000100. Immediate = zext(imm12[21:10]).
- Register logical/arithmetic: `OP_ADD`, `OP_ADDS`, `OP_SUB`, `OP_SUBS`, `OP_AND`, `OP_ANDS`, `OP_ORR`, `OP_EOR`, `OP_MVN` use the 64-bit shifted-register forms with shift amount 0. The top bits [31:21] are:
  - `OP_ADD` 10001011000, `OP_ADDS` 10101011000, `OP_SUB` 11001011000, `OP_SUBS` 11101011000.
  - `OP_AND` 10001010000, `OP_ANDS` 11101010000, `OP_ORR` 10101010000, `OP_EOR` 11001010000.
  - `OP_MVN` 10101010001 with Rn=11111.
  - Immediate 0 for all of these.
- Arithmetic and width rules:
  - All shifts are performed after extension to `GPR_SIZE` bits.
  - Sign extension replicates the field MSB up to bit `GPR_SIZE-1`.
  - Overflow beyond bit `GPR_SIZE-1` is discarded.
- Combinational outputs depend only on `in_insnbits`. They are independent of `in_valid` and `in_rst`.

## Timing
- `out_opcode` and `out_reg_imm` are zero-latency (same cycle). Fetch must be able to use them before the same clock edge.
- Registered outputs have 1-cycle latency. At each rising edge:
  - `out_q_opcode` ← `out_opcode`
  - `out_q_imm` ← `out_reg_imm`
  - `out_q_valid` ← `in_valid`
- There is no handshake or stall. The register updates every cycle.
- Reset values, sampled at a rising edge with `in_rst`=1: `out_q_valid`=0, `out_q_opcode`=`OP_NOP`, `out_q_imm`=0.
- Reset takes priority over the capture of `in_valid` in the same cycle.
- Reset mid-stream drops the instruction being captured. Capture resumes on the first edge with `in_rst`=0.
- When `in_valid`=0, opcode and immediate are still captured. Consumers must ignore them.

## Test plan
- Unconditional branches, same-cycle check:
  - 0x14000001 → `OP_B`, imm 0x4.
  - 0x17FFFFFF → `OP_B`, imm 0xFFFFFFFFFFFFFFFC.
  - 0x94000010 → `OP_BL`, imm 0x40.
- Conditional branch and return:
  - 0x54000040 → `OP_B_COND`, imm 0x8.
  - 0xD65F03C0 → `OP_RET`, imm 0.
- Memory, add and move:
  - 0xF85F8020 → `OP_LDUR`, imm 0xFFFFFFFFFFFFFFF8.
  - 0x91001441 → `OP_ADD`, imm 0x5.
  - 0xD2A24680 → `OP_MOVZ`, imm 0x12340000.
- Error decode:
  - 0x00000000 → `OP_ERROR`, imm 0.
  - 0xFFFFFFFF → `OP_ERROR`, imm 0.
- Pipeline register:
  - Hold `in_rst`=1 for 2 edges → `out_q_valid`=0, `out_q_opcode`=`OP_NOP`, `out_q_imm`=0.
  - Release reset, drive 0x14000001 with `in_valid`=1 → after the next edge `out_q_valid`=1, `OP_B`, imm 0x4.
- Reset mid-stream:
  - Drive valid instructions on consecutive cycles and assert `in_rst` for one edge → `out_q_valid`=0 after that edge.
  - On the following edge, with `in_rst`=0 and 0x94000010 valid → `OP_BL`, imm 0x40, `out_q_valid`=1.
